mem_test_engine: RTL and testbench

Parametrised memory soak tester. It repeatedly writes a full address sweep, reads it back and compares, and counts passed and failed sweeps. It drives a generic req/ack memory master port instead of embedding a controller, so one engine serves DRAM, SRAM or on-chip RAM test builds. It adds four data-pattern modes, first-error capture, a counter clear, and a graceful stop on enable deassert.

---
 rtl/mem_test_engine_pkg.sv | 48 ++++
 rtl/mem_test_engine_if.sv | 25 ++
 rtl/mem_test_engine_lfsr_gen.sv | 40 ++++
 rtl/mem_test_engine.sv | 192 +++++++++++++++++++
 tb/tb_mem_test_engine.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_test_engine_pkg.sv
// mem_test_engine shared types and pattern helper
// FSM encoding, pattern modes, expected-data generator
package mem_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEED    = 3'd1,
    S_WRITE   = 3'd2,
    S_RESTORE = 3'd3,
    S_READ    = 3'd4,
    S_TALLY   = 3'd5
  } state_t;

  localparam logic [1:0] MODE_LFSR = 2'd0;
  localparam logic [1:0] MODE_WALK = 2'd1;
  localparam logic [1:0] MODE_ADDR = 2'd2;
  localparam logic [1:0] MODE_CHK  = 2'd3;

  // widest data bus the helper supports; callers keep the low bits
  localparam int PAT_W = 64;

  function automatic logic [PAT_W-1:0] pattern_gen(
    input logic [1:0]       mode,
    input logic [PAT_W-1:0] addr,
    input logic [PAT_W-1:0] pass,
    input logic [PAT_W-1:0] lfsr_bits,
    input int unsigned      width
  );
    logic [PAT_W-1:0] r;
    logic [PAT_W-1:0] sh;
    r  = '0;
    sh = (addr + pass) % PAT_W'(width);
    unique case (mode)
      MODE_LFSR: r = lfsr_bits;
      MODE_WALK: r = PAT_W'(1) << sh;
      MODE_ADDR: r = addr ^ {PAT_W{pass[0]}};
      MODE_CHK: begin
        if (addr[0] ^ pass[0])
          r = {(PAT_W/2){2'b10}};
        else
          r = {(PAT_W/2){2'b01}};
      end
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_test_engine_if.sv
// mem_test_engine memory master bus
// req/ack handshake, read data valid with ack
interface mem_test_engine_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic              mem_req;
  logic              mem_rnw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdat;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdat;

  modport master (
    output mem_req, mem_rnw,
    output mem_addr, mem_wdat,
    input  mem_ack, mem_rdat
  );

  modport slave (
    input  mem_req, mem_rnw,
    input  mem_addr, mem_wdat,
    output mem_ack, mem_rdat
  );
endinterface

// File: rtl/mem_test_engine_lfsr_gen.sv
// Fibonacci LFSR with save/restore
// restore replays a sweep's data for read-back
module lfsr_gen #(
  parameter int LEN   = 25,
  parameter int TAP   = 22,
  parameter int SEED  = 1,
  parameter int OUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             next,
  input  logic             save,
  input  logic             restore,
  output logic [OUT_W-1:0] out
);

  logic [LEN-1:0] q;
  logic [LEN-1:0] saved;

  // live state: restore beats a step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= LEN'(SEED);
    else if (restore)
      q <= saved;
    else if (next)
      q <= {q[LEN-2:0], q[LEN-1] ^ q[TAP-1]};
  end

  // snapshot taken at sweep start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      saved <= LEN'(SEED);
    else if (save)
      saved <= q;
  end

  assign out = q[OUT_W-1:0];

endmodule

// File: rtl/mem_test_engine.sv
// Memory soak tester: write sweep, read back, compare
// counts clean/failed sweeps, captures first error
module mem_test_engine
  import mem_test_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10,
  parameter int CNT_W     = 16,
  parameter int LFSR_LEN  = 25,
  parameter int LFSR_TAP  = 22,
  parameter int LFSR_SEED = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic              clr,
  mem_test_engine_if.master mem,
  output logic              busy,
  output logic [CNT_W-1:0]  pass_counter,
  output logic [CNT_W-1:0]  fail_counter,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_got
);

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        mode_q;
  logic              pass_err;
  logic [CNT_W-1:0]  pass_idx;
  logic [DATA_W-1:0] lfsr_out;
  logic [DATA_W-1:0] exp_dat;
  logic              req;
  logic              rnw;
  logic              beat;
  logic              last;
  logic              mism;
  logic              cap;
  logic              tally;
  logic              lfsr_next;
  logic              lfsr_save;
  logic              lfsr_restore;

  lfsr_gen #(
    .LEN   (LFSR_LEN),
    .TAP   (LFSR_TAP),
    .SEED  (LFSR_SEED),
    .OUT_W (DATA_W)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .next    (lfsr_next),
    .save    (lfsr_save),
    .restore (lfsr_restore),
    .out     (lfsr_out)
  );

  assign exp_dat = DATA_W'(pattern_gen(
    mode_q,
    PAT_W'(addr_q),
    PAT_W'(pass_idx),
    PAT_W'(lfsr_out),
    DATA_W));

  assign beat  = req & mem.mem_ack;
  assign last  = (addr_q == '1);
  assign mism  = (mem.mem_rdat != exp_dat);
  assign cap   = rnw & beat & mism & ~err_valid;
  assign tally = (state_q == S_TALLY);
  assign busy  = (state_q != S_IDLE);

  assign mem.mem_req  = req;
  assign mem.mem_rnw  = rnw;
  assign mem.mem_addr = addr_q;
  assign mem.mem_wdat = (state_q == S_WRITE) ? exp_dat : '0;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // next state, bus strobes, LFSR control
  always_comb begin
    state_d      = state_q;
    req          = 1'b0;
    rnw          = 1'b0;
    lfsr_next    = 1'b0;
    lfsr_save    = 1'b0;
    lfsr_restore = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable)
          state_d = S_SEED;
      end
      S_SEED: begin
        lfsr_save = 1'b1;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        req = 1'b1;
        if (mem.mem_ack) begin
          lfsr_next = 1'b1;
          if (last)
            state_d = S_RESTORE;
        end
      end
      S_RESTORE: begin
        lfsr_restore = 1'b1;
        state_d      = S_READ;
      end
      S_READ: begin
        req = 1'b1;
        rnw = 1'b1;
        if (mem.mem_ack) begin
          lfsr_next = 1'b1;
          if (last)
            state_d = S_TALLY;
        end
      end
      S_TALLY: begin
        state_d = enable ? S_SEED : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // sweep address, latched mode, sweep error flag, pass index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      mode_q   <= MODE_LFSR;
      pass_err <= 1'b0;
      pass_idx <= '0;
    end else begin
      if (state_q == S_SEED) begin
        mode_q   <= mode;
        pass_err <= 1'b0;
      end
      if (state_q == S_SEED || state_q == S_RESTORE)
        addr_q <= '0;
      else if (beat)
        addr_q <= addr_q + 1'b1;
      if (rnw && beat)
        pass_err <= pass_err | mism;
      if (tally)
        pass_idx <= pass_idx + 1'b1;
    end
  end

  // saturating sweep counters; clr wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_counter <= '0;
      fail_counter <= '0;
    end else if (clr) begin
      pass_counter <= '0;
      fail_counter <= '0;
    end else if (tally) begin
      if (!pass_err && pass_counter != '1)
        pass_counter <= pass_counter + 1'b1;
      if (pass_err && fail_counter != '1)
        fail_counter <= fail_counter + 1'b1;
    end
  end

  // first-error capture; capture wins over clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_exp   <= '0;
      err_got   <= '0;
    end else if (cap) begin
      err_valid <= 1'b1;
      err_addr  <= addr_q;
      err_exp   <= exp_dat;
      err_got   <= mem.mem_rdat;
    end else if (clr) begin
      err_valid <= 1'b0;
      err_addr  <= '0;
      err_exp   <= '0;
      err_got   <= '0;
    end
  end

endmodule

// File: tb/tb_mem_test_engine.sv
// Self-checking bench for mem_test_engine
// RAM model with fault injection and random ack delay
module tb_mem_test_engine;

  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int CW  = 2;
  localparam int LIM = 4000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          clr = 1'b0;
  logic          busy;
  logic [CW-1:0] pass_counter;
  logic [CW-1:0] fail_counter;
  logic          err_valid;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_exp;
  logic [DW-1:0] err_got;

  mem_test_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_test_engine #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .mode         (mode),
    .clr          (clr),
    .mem          (bus),
    .busy         (busy),
    .pass_counter (pass_counter),
    .fail_counter (fail_counter),
    .err_valid    (err_valid),
    .err_addr     (err_addr),
    .err_exp      (err_exp),
    .err_got      (err_got)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // RAM model
  logic [DW-1:0] ram [16];
  logic [DW-1:0] wr0 [16];
  logic [DW-1:0] rd3;
  bit            rd3_seen;
  int            n_wr, n_rd;
  int            flip_a = -1;
  logic [DW-1:0] flip_m = '0;
  int            maxd = 0;
  bit            spur = 0;
  int            wcnt = 0;
  logic          prev_req = 0;
  logic          prev_ack = 0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_wdat;

  initial begin
    bus.mem_ack  = 1'b0;
    bus.mem_rdat = '0;
  end

  // drive ack/rdat just after each edge; check beat stability
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      prev_req = 1'b0;
    end else if (prev_req && !prev_ack) begin
      check("stable_req", bus.mem_req, 1);
      check("stable_addr", bus.mem_addr, prev_addr);
      check("stable_wdat", bus.mem_wdat, prev_wdat);
    end
    if (bus.mem_req) begin
      if (wcnt == 0) begin
        bus.mem_ack = 1'b1;
        wcnt = $urandom_range(0, maxd);
      end else begin
        bus.mem_ack = 1'b0;
        wcnt--;
      end
    end else begin
      bus.mem_ack = spur;
    end
    bus.mem_rdat = ram[bus.mem_addr];
    if (int'(bus.mem_addr) == flip_a)
      bus.mem_rdat = bus.mem_rdat ^ flip_m;
    prev_req  = bus.mem_req & rst_n;
    prev_ack  = bus.mem_ack;
    prev_addr = bus.mem_addr;
    prev_wdat = bus.mem_wdat;
  end

  // commit accepted beats mid-cycle
  always @(negedge clk) begin
    if (rst_n && bus.mem_req && bus.mem_ack) begin
      if (!bus.mem_rnw) begin
        ram[bus.mem_addr] = bus.mem_wdat;
        if (n_wr < 16)
          wr0[bus.mem_addr] = bus.mem_wdat;
        n_wr++;
      end else begin
        if (bus.mem_addr == 4'd3 && !rd3_seen) begin
          rd3      = bus.mem_rdat;
          rd3_seen = 1;
        end
        n_rd++;
      end
    end
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    enable   = 1'b0;
    clr      = 1'b0;
    n_wr     = 0;
    n_rd     = 0;
    rd3_seen = 0;
    rd3      = 'x;
    wcnt     = 0;
    for (int k = 0; k < 16; k++)
      wr0[k] = 'x;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic run_sweeps(input int n);
    int cyc;
    enable = 1'b1;
    for (cyc = 0; cyc < LIM; cyc++) begin
      @(posedge clk);
      #2;
      if (n_rd >= 16 * (n - 1) + 1)
        enable = 1'b0;
      if (!enable && !busy)
        break;
    end
    check("run_done", cyc < LIM, 1);
  endtask

  task automatic wait_beat(input logic rnw,
                           input logic [AW-1:0] a);
    int cyc;
    for (cyc = 0; cyc < LIM; cyc++) begin
      @(posedge clk);
      #2;
      if (bus.mem_req && bus.mem_rnw == rnw &&
          bus.mem_addr == a)
        break;
    end
    check("wait_beat", cyc < LIM, 1);
  endtask

  task automatic wait_reads(input int n);
    int cyc;
    for (cyc = 0; cyc < LIM; cyc++) begin
      @(posedge clk);
      #2;
      if (n_rd >= n)
        break;
    end
    check("wait_reads", cyc < LIM, 1);
  endtask

  typedef struct {
    logic [1:0]    mode;
    int            fa;
    logic [DW-1:0] fm;
    int            sweeps;
    int            md;
    int            ca;
    logic [DW-1:0] cw;
    logic [DW-1:0] r3;
    int            pc;
    int            fc;
    logic          ev;
    logic [AW-1:0] ea;
    logic [DW-1:0] ee;
    logic [DW-1:0] eg;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'd0, -1, 16'h0000, 3, 0, 15, 16'h8000,
                16'h0008, 3, 0, 1'b0, 4'd0, 16'h0000, 16'h0000};
    vecs[1] = '{2'd2, 5, 16'h0001, 1, 0, 5, 16'h0005,
                16'h0003, 0, 1, 1'b1, 4'd5, 16'h0005, 16'h0004};
    vecs[2] = '{2'd1, -1, 16'h0000, 2, 3, 3, 16'h0008,
                16'h0008, 2, 0, 1'b0, 4'd0, 16'h0000, 16'h0000};
    vecs[3] = '{2'd3, 2, 16'h8000, 2, 0, 1, 16'hAAAA,
                16'hAAAA, 0, 2, 1'b1, 4'd2, 16'h5555, 16'hD555};
    vecs[4] = '{2'd2, 9, 16'h00F0, 1, 1, 9, 16'h0009,
                16'h0003, 0, 1, 1'b1, 4'd9, 16'h0009, 16'h00F9};
    vecs[5] = '{2'd1, 3, 16'h0001, 5, 1, 15, 16'h8000,
                16'h0009, 0, 3, 1'b1, 4'd3, 16'h0008, 16'h0009};
    vecs[6] = '{2'd0, 0, 16'h0002, 1, 0, 4, 16'h0010,
                16'h0008, 0, 1, 1'b1, 4'd0, 16'h0001, 16'h0003};

    do_reset();
    check("rst_busy", busy, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_pass", pass_counter, 0);
    check("rst_errv", err_valid, 0);

    for (int i = 0; i < 7; i++) begin
      vec_t v;
      v = vecs[i];
      flip_a = v.fa;
      flip_m = v.fm;
      maxd   = v.md;
      spur   = (v.md > 0);
      mode   = v.mode;
      do_reset();
      run_sweeps(v.sweeps);
      check($sformatf("v%0d_pass", i), pass_counter, v.pc);
      check($sformatf("v%0d_fail", i), fail_counter, v.fc);
      check($sformatf("v%0d_errv", i), err_valid, v.ev);
      check($sformatf("v%0d_eaddr", i), err_addr, v.ea);
      check($sformatf("v%0d_eexp", i), err_exp, v.ee);
      check($sformatf("v%0d_egot", i), err_got, v.eg);
      check($sformatf("v%0d_nwr", i), n_wr, 16 * v.sweeps);
      check($sformatf("v%0d_nrd", i), n_rd, 16 * v.sweeps);
      check($sformatf("v%0d_wdat", i), wr0[v.ca], v.cw);
      check($sformatf("v%0d_rd3", i), rd3, v.r3);
      check($sformatf("v%0d_busy", i), busy, 0);
    end
    spur = 0;
    maxd = 0;

    // enable dropped mid-read: sweep completes once
    flip_a = -1;
    mode   = 2'd0;
    do_reset();
    enable = 1'b1;
    wait_beat(1'b1, 4'd7);
    enable = 1'b0;
    wait_reads(16);
    check("drop_tally_busy", busy, 1);
    check("drop_tally_pass", pass_counter, 0);
    @(posedge clk);
    #2;
    check("drop_idle_busy", busy, 0);
    check("drop_pass", pass_counter, 1);
    repeat (3) @(posedge clk);
    #2;
    check("drop_nrd", n_rd, 16);
    check("drop_stay_idle", busy, 0);

    // clr in the same cycle as a TALLY increment
    mode = 2'd2;
    do_reset();
    enable = 1'b1;
    wait_reads(16);
    check("clrt_pre", pass_counter, 0);
    clr    = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #2;
    clr = 1'b0;
    check("clrt_pass", pass_counter, 0);
    check("clrt_fail", fail_counter, 0);
    check("clrt_busy", busy, 0);

    // clr in the same cycle as an error capture
    flip_a = 0;
    flip_m = 16'h0100;
    do_reset();
    enable = 1'b1;
    wait_beat(1'b1, 4'd0);
    clr    = 1'b1;
    enable = 1'b0;
    @(posedge clk);
    #2;
    clr = 1'b0;
    check("clre_errv", err_valid, 1);
    check("clre_eaddr", err_addr, 0);
    check("clre_eexp", err_exp, 16'h0000);
    check("clre_egot", err_got, 16'h0100);
    wait_reads(16);
    repeat (2) @(posedge clk);
    #2;
    check("clre_fail", fail_counter, 1);
    clr = 1'b1;
    @(posedge clk);
    #2;
    clr = 1'b0;
    check("clr_errv", err_valid, 0);
    check("clr_egot", err_got, 0);
    check("clr_fail", fail_counter, 0);

    // async reset mid-write, then clean restart
    flip_a = 1;
    flip_m = 16'h0001;
    mode   = 2'd0;
    do_reset();
    run_sweeps(1);
    check("ar_pre_fail", fail_counter, 1);
    check("ar_pre_errv", err_valid, 1);
    flip_a = -1;
    enable = 1'b1;
    wait_beat(1'b0, 4'd6);
    rst_n = 1'b0;
    #1;
    check("ar_req", bus.mem_req, 0);
    check("ar_rnw", bus.mem_rnw, 0);
    check("ar_addr", bus.mem_addr, 0);
    check("ar_wdat", bus.mem_wdat, 0);
    check("ar_busy", busy, 0);
    check("ar_fail", fail_counter, 0);
    check("ar_errv", err_valid, 0);
    check("ar_eaddr", err_addr, 0);
    check("ar_eexp", err_exp, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("ar_seed_busy", busy, 1);
    check("ar_seed_req", bus.mem_req, 0);
    @(posedge clk);
    #2;
    check("ar_w0_req", bus.mem_req, 1);
    check("ar_w0_rnw", bus.mem_rnw, 0);
    check("ar_w0_addr", bus.mem_addr, 0);
    check("ar_w0_wdat", bus.mem_wdat, 16'h0001);
    @(posedge clk);
    #2;
    check("ar_w1_addr", bus.mem_addr, 1);
    check("ar_w1_wdat", bus.mem_wdat, 16'h0002);
    enable = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
